// File: rtl/dram_av_bridge.sv
// MCU external-DRAM port to Avalon-MM slave bridge: one active plus one queued
// request, waitrequest back-pressure, one-cycle ack and a watchdog abort.
module dram_av_bridge #(
    parameter int ADDR_BITS      = 22,
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                   clk,
    input  logic                   sync_reset,
    input  logic [ADDR_BITS-1:0]   mem_addr,
    input  logic                   mem_read_en,
    input  logic                   mem_write_en,
    input  logic [XLEN/8-1:0]      mem_byte_enable,
    input  logic [XLEN-1:0]        mem_write_data,
    output logic                   mem_ack,
    output logic [XLEN-1:0]        mem_read_data,
    output logic [ADDR_BITS+1:0]   av_address,
    output logic                   av_read,
    output logic                   av_write,
    output logic [XLEN/8-1:0]      av_byteenable,
    output logic [XLEN-1:0]        av_writedata,
    input  logic                   av_waitrequest,
    input  logic [XLEN-1:0]        av_readdata,
    input  logic                   av_readdatavalid,
    output logic                   busy,
    output logic                   timeout_error,
    output logic                   protocol_error
);
    localparam int BE_W  = XLEN / 8;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RD_WAIT, S_ACK} state_t;

    state_t                r_state, w_state_n;
    logic [ADDR_BITS-1:0]  r_act_addr, w_act_addr_n, r_slot_addr, w_slot_addr_n;
    logic [BE_W-1:0]       r_act_be, w_act_be_n, r_slot_be, w_slot_be_n;
    logic [XLEN-1:0]       r_act_data, w_act_data_n, r_slot_data, w_slot_data_n;
    logic                  r_act_wr, w_act_wr_n, r_slot_wr, w_slot_wr_n;
    logic                  r_slot_valid, w_slot_valid_n;
    logic [CNT_W-1:0]      r_wdog, w_wdog_n;
    logic [XLEN-1:0]       r_rdata, w_rdata_n;
    logic                  r_tmo_err, w_tmo_err_n, r_perr, w_perr_n;
    logic                  r_ack, r_av_read, r_av_write, r_busy;
    logic                  w_req, w_expired;

    assign w_req     = mem_read_en | mem_write_en;
    assign w_expired = (r_wdog >= CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state_n      = r_state;
        w_act_addr_n   = r_act_addr;
        w_act_be_n     = r_act_be;
        w_act_data_n   = r_act_data;
        w_act_wr_n     = r_act_wr;
        w_slot_addr_n  = r_slot_addr;
        w_slot_be_n    = r_slot_be;
        w_slot_data_n  = r_slot_data;
        w_slot_wr_n    = r_slot_wr;
        w_slot_valid_n = r_slot_valid;
        w_wdog_n       = r_wdog;
        w_rdata_n      = r_rdata;
        w_tmo_err_n    = r_tmo_err;
        w_perr_n       = r_perr;

        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_act_addr_n = mem_addr;
                    w_act_be_n   = mem_byte_enable;
                    w_act_data_n = mem_write_data;
                    w_act_wr_n   = mem_write_en;
                    w_wdog_n     = '0;
                    w_state_n    = S_REQ;
                end
            end
            S_REQ: begin
                // an accepted command wins over a watchdog expiring in the same cycle
                if (!av_waitrequest) begin
                    w_state_n = r_act_wr ? S_ACK : S_RD_WAIT;
                    w_wdog_n  = r_wdog + CNT_W'(1);
                end else if (w_expired) begin
                    w_tmo_err_n = 1'b1;
                    if (!r_act_wr) w_rdata_n = '1;
                    w_state_n = S_ACK;
                end else begin
                    w_wdog_n = r_wdog + CNT_W'(1);
                end
            end
            S_RD_WAIT: begin
                if (av_readdatavalid) begin
                    w_rdata_n = av_readdata;
                    w_state_n = S_ACK;
                end else if (w_expired) begin
                    w_tmo_err_n = 1'b1;
                    w_rdata_n   = '1;
                    w_state_n   = S_ACK;
                end else begin
                    w_wdog_n = r_wdog + CNT_W'(1);
                end
            end
            S_ACK: begin
                if (r_slot_valid) begin
                    w_act_addr_n   = r_slot_addr;
                    w_act_be_n     = r_slot_be;
                    w_act_data_n   = r_slot_data;
                    w_act_wr_n     = r_slot_wr;
                    w_slot_valid_n = 1'b0;
                    w_wdog_n       = '0;
                    w_state_n      = S_REQ;
                end else if (w_req) begin
                    w_act_addr_n = mem_addr;
                    w_act_be_n   = mem_byte_enable;
                    w_act_data_n = mem_write_data;
                    w_act_wr_n   = mem_write_en;
                    w_wdog_n     = '0;
                    w_state_n    = S_REQ;
                end else begin
                    w_state_n = S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase

        // ACK with an empty slot forwards the request straight to the active register
        if (w_req && (r_state != S_IDLE) && !(r_state == S_ACK && !r_slot_valid)) begin
            if (!r_slot_valid || r_state == S_ACK) begin
                w_slot_addr_n  = mem_addr;
                w_slot_be_n    = mem_byte_enable;
                w_slot_data_n  = mem_write_data;
                w_slot_wr_n    = mem_write_en;
                w_slot_valid_n = 1'b1;
            end else begin
                w_perr_n = 1'b1;
            end
        end
        if (mem_read_en && mem_write_en) w_perr_n = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_state      <= S_IDLE;
            r_act_addr   <= '0;
            r_act_be     <= '0;
            r_act_data   <= '0;
            r_act_wr     <= 1'b0;
            r_slot_addr  <= '0;
            r_slot_be    <= '0;
            r_slot_data  <= '0;
            r_slot_wr    <= 1'b0;
            r_slot_valid <= 1'b0;
            r_wdog       <= '0;
            r_rdata      <= '0;
            r_tmo_err    <= 1'b0;
            r_perr       <= 1'b0;
            r_ack        <= 1'b0;
            r_av_read    <= 1'b0;
            r_av_write   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_act_addr   <= w_act_addr_n;
            r_act_be     <= w_act_be_n;
            r_act_data   <= w_act_data_n;
            r_act_wr     <= w_act_wr_n;
            r_slot_addr  <= w_slot_addr_n;
            r_slot_be    <= w_slot_be_n;
            r_slot_data  <= w_slot_data_n;
            r_slot_wr    <= w_slot_wr_n;
            r_slot_valid <= w_slot_valid_n;
            r_wdog       <= w_wdog_n;
            r_rdata      <= w_rdata_n;
            r_tmo_err    <= w_tmo_err_n;
            r_perr       <= w_perr_n;
            r_ack        <= (w_state_n == S_ACK);
            r_av_read    <= (w_state_n == S_REQ) && !w_act_wr_n;
            r_av_write   <= (w_state_n == S_REQ) && w_act_wr_n;
            r_busy       <= (w_state_n != S_IDLE) || w_slot_valid_n;
        end
    end

    assign mem_ack        = r_ack;
    assign mem_read_data  = r_rdata;
    assign av_address     = {r_act_addr, 2'b00};
    assign av_read        = r_av_read;
    assign av_write       = r_av_write;
    assign av_byteenable  = r_act_be;
    assign av_writedata   = r_act_data;
    assign busy           = r_busy;
    assign timeout_error  = r_tmo_err;
    assign protocol_error = r_perr;
endmodule

// File: tb/tb_dram_av_bridge.sv
// Directed bench for dram_av_bridge: expected acks are queued at request time
// and matched (cycle and read data) by a monitor when mem_ack pulses.
module tb_dram_av_bridge;
    logic        clk = 1'b0;
    logic        sync_reset;
    logic [21:0] mem_addr;
    logic        mem_read_en, mem_write_en;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_write_data;
    logic        mem_ack;
    logic [31:0] mem_read_data;
    logic [23:0] av_address;
    logic        av_read, av_write;
    logic [3:0]  av_byteenable;
    logic [31:0] av_writedata;
    logic        av_waitrequest;
    logic [31:0] av_readdata;
    logic        av_readdatavalid;
    logic        busy, timeout_error, protocol_error;

    dram_av_bridge #(.ADDR_BITS(22), .XLEN(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .sync_reset(sync_reset),
        .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_byte_enable(mem_byte_enable), .mem_write_data(mem_write_data),
        .mem_ack(mem_ack), .mem_read_data(mem_read_data),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_byteenable(av_byteenable), .av_writedata(av_writedata),
        .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
        .av_readdatavalid(av_readdatavalid),
        .busy(busy), .timeout_error(timeout_error), .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   ack_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_ack) begin
            exp_t e;
            ack_count++;
            chk("ack_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.cyc >= 0) chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                if (e.is_rd) chk("ack_rdata", 64'(mem_read_data), 64'(e.data));
            end
        end
    end

    task automatic push_exp(input bit rd, input logic [31:0] d, input int c);
        exp_t e;
        e.is_rd = rd;
        e.data  = d;
        e.cyc   = c;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
    endtask

    task automatic rd_req(input logic [21:0] a);
        mem_addr    = a;
        mem_read_en = 1'b1;
    endtask

    initial begin
        int c0;
        int a0;
        int n;
        sync_reset = 1'b1;
        mem_addr = '0; mem_read_en = 0; mem_write_en = 0;
        mem_byte_enable = '0; mem_write_data = '0;
        av_waitrequest = 0; av_readdata = '0; av_readdatavalid = 0;
        repeat (3) tick();

        chk("rst_cmds", {av_read, av_write, mem_ack, busy}, 0);
        chk("rst_flags", {timeout_error, protocol_error}, 0);
        chk("rst_rdata", mem_read_data, 0);
        chk("rst_addr", av_address, 0);
        sync_reset = 1'b0;
        tick();

        // write, zero wait states
        c0 = cyc;
        mem_addr = 22'h000010; mem_write_en = 1; mem_byte_enable = 4'hF;
        mem_write_data = 32'hCAFEBABE;
        push_exp(0, '0, c0 + 2);
        tick();
        chk("wr_av_write", {av_write, av_read}, 2'b10);
        chk("wr_av_address", av_address, 24'h000040);
        chk("wr_av_data", {av_byteenable, av_writedata}, {4'hF, 32'hCAFEBABE});
        chk("wr_busy", busy, 1);
        tick();
        chk("wr_ack_pulse", {mem_ack, av_write}, 2'b10);
        tick();
        chk("wr_idle", {mem_ack, busy}, 0);

        // read with 3 waitrequest cycles; stray readdatavalid during REQ
        c0 = cyc;
        av_waitrequest = 1;
        rd_req(22'h3FFFFF);
        push_exp(1, 32'h12345678, c0 + 7);
        tick();
        chk("rd_av_address", av_address, 24'hFFFFFC);
        chk("rd_av_read", av_read, 1);
        tick();
        av_readdatavalid = 1; av_readdata = 32'hDEADBEEF;
        tick();
        av_readdatavalid = 0;
        chk("rd_hold_cmd", {av_read, av_address}, {1'b1, 24'hFFFFFC});
        tick();
        av_waitrequest = 0;
        tick();
        chk("rd_cmd_drop", av_read, 0);
        tick();
        av_readdatavalid = 1; av_readdata = 32'h12345678;
        tick();
        av_readdatavalid = 0;
        chk("rd_ack_data", {mem_ack, mem_read_data}, {1'b1, 32'h12345678});
        tick();
        chk("rd_data_held", {mem_ack, mem_read_data}, {1'b0, 32'h12345678});

        // second read queued during RD_WAIT of the first
        a0 = ack_count;
        c0 = cyc;
        rd_req(22'h000100);
        push_exp(1, 32'hAAAA0001, c0 + 4);
        tick();
        tick();
        rd_req(22'h000200);
        push_exp(1, 32'hBBBB0002, c0 + 7);
        tick();
        av_readdatavalid = 1; av_readdata = 32'hAAAA0001;
        tick();
        av_readdatavalid = 0;
        chk("q_ack_busy", {mem_ack, busy}, 2'b11);
        tick();
        chk("q_second_cmd", {av_read, av_address}, {1'b1, 24'h000800});
        tick();
        av_readdatavalid = 1; av_readdata = 32'hBBBB0002;
        tick();
        av_readdatavalid = 0;
        tick();
        chk("q_two_acks", 64'(ack_count - a0), 2);
        chk("q_no_perr", protocol_error, 0);

        // third request while slot full and not draining is dropped
        a0 = ack_count;
        c0 = cyc;
        av_waitrequest = 1;
        rd_req(22'h000300);
        push_exp(1, 32'hC0C0C0C0, c0 + 5);
        tick();
        rd_req(22'h000301);
        push_exp(1, 32'hD0D0D0D0, c0 + 8);
        tick();
        rd_req(22'h000302);
        tick();
        chk("drop_perr", protocol_error, 1);
        av_waitrequest = 0;
        tick();
        av_readdatavalid = 1; av_readdata = 32'hC0C0C0C0;
        tick();
        av_readdatavalid = 0;
        tick();
        chk("drop_slot_cmd", {av_read, av_address}, {1'b1, 24'h000C04});
        tick();
        av_readdatavalid = 1; av_readdata = 32'hD0D0D0D0;
        tick();
        av_readdatavalid = 0;
        repeat (4) tick();
        chk("drop_two_acks", 64'(ack_count - a0), 2);
        chk("drop_idle", busy, 0);

        // watchdog abort on a read that never returns data
        chk("pre_tmo_flag", timeout_error, 0);
        a0 = ack_count;
        rd_req(22'h000400);
        push_exp(1, 32'hFFFFFFFF, -1);
        n = 0;
        tick();
        while (ack_count == a0 && n < 40) begin
            tick();
            n++;
        end
        chk("tmo_ack_seen", 64'(ack_count - a0), 1);
        chk("tmo_flag", timeout_error, 1);
        av_readdatavalid = 1; av_readdata = 32'h00000055;
        tick();
        av_readdatavalid = 0;
        tick();
        chk("tmo_late_ignored", {mem_read_data, mem_ack, busy}, {32'hFFFFFFFF, 2'b00});
        chk("tmo_no_extra_ack", 64'(ack_count - a0), 1);

        // sync_reset during REQ with a queued request
        a0 = ack_count;
        av_waitrequest = 1;
        rd_req(22'h0003AB);
        tick();
        chk("rst_mid_cmd", av_read, 1);
        rd_req(22'h0003AC);
        tick();
        sync_reset = 1;
        tick();
        sync_reset = 0;
        chk("rst_mid_outputs", {av_read, av_write, busy, mem_ack}, 0);
        chk("rst_mid_flags", {timeout_error, protocol_error}, 0);
        chk("rst_mid_rdata", mem_read_data, 0);
        av_waitrequest = 0;
        repeat (10) tick();
        chk("rst_slot_discarded", {64'(ack_count - a0)}, 0);
        chk("rst_stays_idle", {av_read, busy}, 0);
        chk("sb_drained", 64'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
